// File: rtl/onehot_addr_guard.sv
// Binary-to-one-hot encoder with an independent checker on a buffered copy of the
// select vector; flags multi-hot, enable-inconsistent and wrong-index strobes.

module onehot_addr_guard_buf #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in_i;
endmodule

module onehot_addr_guard #(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned OneHotWidth = 2 ** AddrWidth,
  parameter bit          EnableCheck = 1'b1,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          StrictCheck = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  input  logic [OneHotWidth-1:0] inj_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic [2:0]             err_cause_o,
  output logic                   err_o,
  output logic                   err_q_o
);

  // Tree leaves padded to a power of two (at least 2) so every node has two children.
  localparam int unsigned NumLeaves =
      (OneHotWidth < 2) ? 2 : (1 << $clog2(OneHotWidth));
  localparam int unsigned LeafIdxW  = $clog2(NumLeaves);

  if (OneHotWidth > 2 ** AddrWidth) begin : gen_err_width
    $error("OneHotWidth must not exceed 2**AddrWidth");
  end
  if (AddrCheck && !EnableCheck) begin : gen_err_addrcheck
    $error("AddrCheck requires EnableCheck");
  end
  if (StrictCheck && !EnableCheck) begin : gen_err_strictcheck
    $error("StrictCheck requires EnableCheck");
  end

  logic [OneHotWidth-1:0] w_oh;
  logic [OneHotWidth-1:0] w_oh_buf;
  logic [OneHotWidth-1:0] w_chk;
  logic [OneHotWidth-1:0] w_addr_mis;
  logic [NumLeaves-1:0]   w_chk_pad;
  logic                   w_any;
  logic                   w_onehot_err;
  logic                   w_enable_err;
  logic                   w_addr_err;
  logic                   w_err;
  logic                   r_err_q;

  // Encoder and per-bit "set at the wrong index" terms; the full address is compared.
  for (genvar i = 0; i < OneHotWidth; i++) begin : gen_bit
    assign w_oh[i]       = en_i && (addr_i == AddrWidth'(i));
    assign w_addr_mis[i] = w_chk[i] && (addr_i != AddrWidth'(i));
  end

  // Kept as its own instance so the checker cannot be folded back into the encoder.
  onehot_addr_guard_buf #(
    .Width (OneHotWidth)
  ) u_buf (
    .in_i  (w_oh),
    .out_o (w_oh_buf)
  );

  assign w_chk     = w_oh_buf ^ inj_i;
  assign w_chk_pad = NumLeaves'(w_chk);

  // Balanced pairwise reduction tracking "any set" and "two or more set" per node.
  function automatic logic [1:0] tree_reduce(input logic [NumLeaves-1:0] v);
    logic [NumLeaves-1:0] any_q;
    logic [NumLeaves-1:0] two_q;
    any_q = v;
    two_q = '0;
    for (int unsigned w = NumLeaves / 2; w >= 1; w = w / 2) begin
      for (int unsigned n = 0; n < w; n++) begin
        two_q[LeafIdxW'(n)] = two_q[LeafIdxW'(2 * n)] | two_q[LeafIdxW'(2 * n + 1)] |
                              (any_q[LeafIdxW'(2 * n)] & any_q[LeafIdxW'(2 * n + 1)]);
        any_q[LeafIdxW'(n)] = any_q[LeafIdxW'(2 * n)] | any_q[LeafIdxW'(2 * n + 1)];
      end
    end
    return {two_q[0], any_q[0]};
  endfunction

  assign {w_onehot_err, w_any} = tree_reduce(w_chk_pad);

  if (EnableCheck) begin : gen_enable_check
    assign w_enable_err = (!en_i && w_any) || (StrictCheck && en_i && !w_any);
  end else begin : gen_no_enable_check
    assign w_enable_err = 1'b0;
  end

  if (AddrCheck) begin : gen_addr_check
    assign w_addr_err = en_i && (|w_addr_mis);
  end else begin : gen_no_addr_check
    assign w_addr_err = 1'b0;
  end

  assign w_err       = w_addr_err | w_enable_err | w_onehot_err;
  assign oh_o        = w_oh;
  assign err_cause_o = {w_addr_err, w_enable_err, w_onehot_err};
  assign err_o       = w_err;

  // Sticky error flag; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_q <= 1'b0;
    end else begin
      r_err_q <= r_err_q | w_err;
    end
  end

  assign err_q_o = r_err_q;

endmodule

// File: tb/tb_onehot_addr_guard.sv
// Randomized and directed bench for onehot_addr_guard against a set-level reference model;
// a second instance runs with strict enable checking.

module tb_onehot_addr_guard;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic        en;
  logic [31:0] inj;

  logic [31:0] oh0, oh1;
  logic [2:0]  cause0, cause1;
  logic        err0, err1, errq0, errq1;

  logic        exp_q0, exp_q1;
  int          n_checks;
  int          n_errors;

  onehot_addr_guard #(.AddrWidth(5), .OneHotWidth(32), .StrictCheck(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .inj_i(inj),
    .oh_o(oh0), .err_cause_o(cause0), .err_o(err0), .err_q_o(errq0)
  );

  onehot_addr_guard #(.AddrWidth(5), .OneHotWidth(32), .StrictCheck(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .inj_i(inj),
    .oh_o(oh1), .err_cause_o(cause1), .err_o(err1), .err_q_o(errq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (addr=%0d en=%0b inj=0x%08h rst=%0b)",
               tag, got, exp, addr, en, inj, rst);
    end
  endtask

  // Reference: selected set vs. observed set, counted with plain popcount.
  function automatic logic [2:0] model_cause(input logic [4:0] a, input logic e,
                                             input logic [31:0] fault, input bit strict);
    logic [31:0] want;
    logic [31:0] seen;
    int          ones;
    logic        oh_err, en_err, ad_err;
    want   = e ? (32'd1 << a) : 32'd0;
    seen   = want ^ fault;
    ones   = $countones(seen);
    oh_err = ones > 1;
    en_err = (!e && ones != 0) || (strict && e && ones == 0);
    ad_err = e && ((seen & ~(32'd1 << a)) != 32'd0);
    return {ad_err, en_err, oh_err};
  endfunction

  // Inputs are already applied; check at negedge, then advance the sticky model at posedge.
  task automatic step();
    logic [2:0] c0, c1;
    c0 = model_cause(addr, en, inj, 1'b0);
    c1 = model_cause(addr, en, inj, 1'b1);
    @(negedge clk);
    check("oh",     oh0,    en ? (32'd1 << addr) : 32'd0);
    check("oh_s",   oh1,    en ? (32'd1 << addr) : 32'd0);
    check("cause",  32'(cause0), 32'(c0));
    check("cause_s",32'(cause1), 32'(c1));
    check("err",    32'(err0),   32'(|c0));
    check("err_s",  32'(err1),   32'(|c1));
    check("errq",   32'(errq0),  32'(exp_q0));
    check("errq_s", 32'(errq1),  32'(exp_q1));
    @(posedge clk);
    exp_q0 = rst ? 1'b0 : (exp_q0 | (|c0));
    exp_q1 = rst ? 1'b0 : (exp_q1 | (|c1));
    #1;
  endtask

  task automatic drive(input logic r, input logic [4:0] a, input logic e, input logic [31:0] f);
    rst  = r;
    addr = a;
    en   = e;
    inj  = f;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_q0   = 1'b0;
    exp_q1   = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    step();

    // Clean sweep: never an error.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'(a), 1'b1, 32'd0);
      step();
    end
    check("sweep_errq", 32'(errq0), 32'd0);

    // Enable error, sticky after fault removed.
    drive(1'b0, 5'd7, 1'b0, 32'h0000_0080);
    step();
    check("en_err_cause", 32'(cause0), 32'b010);
    drive(1'b0, 5'd7, 1'b0, 32'd0);
    step();
    step();
    check("sticky_errq", 32'(errq0), 32'd1);
    drive(1'b1, 5'd7, 1'b0, 32'd0);
    step();
    drive(1'b0, 5'd7, 1'b0, 32'd0);
    step();
    check("cleared_errq", 32'(errq0), 32'd0);

    // Multi-hot plus wrong index.
    drive(1'b0, 5'd3, 1'b1, 32'h0000_0020);
    step();
    check("multi_cause", 32'(cause0), 32'b101);

    // Single bit at the wrong index.
    drive(1'b0, 5'd4, 1'b1, 32'h0000_0030);
    step();
    check("wrongidx_cause", 32'(cause0), 32'b100);

    // Fault cancels the selected bit: only strict mode objects.
    drive(1'b1, 5'd9, 1'b1, 32'd1 << 9);
    step();
    drive(1'b0, 5'd9, 1'b1, 32'd1 << 9);
    step();
    check("zero_err",     32'(err0),   32'd0);
    check("zero_cause_s", 32'(cause1), 32'b010);

    // Reset wins over a persisting fault, then the error is recaptured.
    drive(1'b0, 5'd7, 1'b0, 32'h0000_0080);
    step();
    drive(1'b1, 5'd7, 1'b0, 32'h0000_0080);
    step();
    drive(1'b0, 5'd7, 1'b0, 32'h0000_0080);
    @(negedge clk);
    check("rst_wins_errq", 32'(errq0), 32'd0);
    @(posedge clk);
    #1;
    exp_q0 = 1'b1;
    exp_q1 = 1'b1;
    @(negedge clk);
    check("recapture_errq", 32'(errq0), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional reset and sparse faults.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] f;
      case ($urandom_range(0, 3))
        0, 1:    f = 32'd0;
        2:       f = 32'd1 << $urandom_range(0, 31);
        default: f = $urandom();
      endcase
      drive(($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), f);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
